de2_115_sopc_i2c_target: RTL and testbench

I2C target (responder) with an Avalon-MM CSR slave. It answers a 7-bit bus address and exposes four 8-bit registers to the bus initiator; the Nios II side sees the same registers through the SOPC fabric. It is the far end of the bit-banged SCL/SDA PIO initiator and is used for loopback bring-up and as an on-FPGA configuration target.

---
 rtl/de2_115_sopc_i2c_target.sv | 205 ++++++++++++++++++++
 tb/tb_de2_115_sopc_i2c_target.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/de2_115_sopc_i2c_target.sv
// rtl/de2_115_sopc_i2c_target.sv - I2C target exposing four 8-bit registers, shared with an Avalon-MM CSR slave
`timescale 1ns/1ps
module de2_115_sopc_i2c_target #(
  parameter logic [6:0] I2C_ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        scl,
  inout  wire         sda
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT
  } state_t;

  state_t      state, state_n;
  logic [7:0]  shift, shift_n;
  logic [2:0]  cnt, cnt_n;
  logic        pend, pend_n;
  logic        rw, rw_n;
  logic        first, first_n;
  logic [1:0]  ptr, ptr_n;
  logic        sda_oe, oe_n;
  logic        i2c_wr;

  logic [7:0]  regs [4];
  logic [3:0]  dirty;

  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;
  logic scl_rise, scl_fall, sda_rise, sda_fall, start_cond, stop_cond;
  logic av_wr, av_rd;
  logic unused_wdata;

  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign unused_wdata = ^writedata[31:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_h} <= {scl, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_h} <= {sda, sda_s1, sda_s2};
    end
  end

  assign scl_rise   = scl_s2 & ~scl_h;
  assign scl_fall   = ~scl_s2 & scl_h;
  assign sda_rise   = sda_s2 & ~sda_h;
  assign sda_fall   = ~sda_s2 & sda_h;
  // SCL must be stably high across both samples for a bus condition
  assign start_cond = sda_fall & scl_s2 & scl_h;
  assign stop_cond  = sda_rise & scl_s2 & scl_h;

  assign av_wr = chipselect & ~write_n;
  assign av_rd = chipselect & write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      shift  <= 8'h00;
      cnt    <= 3'd0;
      pend   <= 1'b0;
      rw     <= 1'b0;
      first  <= 1'b0;
      ptr    <= 2'd0;
      sda_oe <= 1'b0;
    end else begin
      state  <= state_n;
      shift  <= shift_n;
      cnt    <= cnt_n;
      pend   <= pend_n;
      rw     <= rw_n;
      first  <= first_n;
      ptr    <= ptr_n;
      sda_oe <= oe_n;
    end
  end

  // pend marks a completed byte (or a received master ACK) waiting for the next SCL fall
  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n   = cnt;
    pend_n  = pend;
    rw_n    = rw;
    first_n = first;
    ptr_n   = ptr;
    oe_n    = sda_oe;
    i2c_wr  = 1'b0;
    if (start_cond) begin
      state_n = S_ADDR;
      cnt_n   = 3'd0;
      pend_n  = 1'b0;
      oe_n    = 1'b0;
    end else if (stop_cond) begin
      state_n = S_IDLE;
      cnt_n   = 3'd0;
      pend_n  = 1'b0;
      oe_n    = 1'b0;
    end else begin
      case (state)
        S_ADDR, S_WR_BYTE: begin
          if (scl_rise) begin
            shift_n = {shift[6:0], sda_s2};
            cnt_n   = cnt + 3'd1;
            pend_n  = (cnt == 3'd7);
          end else if (scl_fall && pend) begin
            pend_n = 1'b0;
            if (state == S_ADDR) begin
              if (shift[7:1] == I2C_ADDR) begin
                oe_n    = 1'b1;
                rw_n    = shift[0];
                state_n = S_ADDR_ACK;
              end else begin
                state_n = S_WAIT;
              end
            end else begin
              oe_n    = 1'b1;
              state_n = S_WR_ACK;
              if (first) begin
                ptr_n   = shift[1:0];
                first_n = 1'b0;
              end else begin
                i2c_wr = 1'b1;
                ptr_n  = ptr + 2'd1;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_n = 3'd0;
            if (rw) begin
              shift_n = regs[ptr];
              oe_n    = ~regs[ptr][7];
              state_n = S_RD_BYTE;
            end else begin
              oe_n    = 1'b0;
              first_n = 1'b1;
              state_n = S_WR_BYTE;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            oe_n    = 1'b0;
            state_n = S_WR_BYTE;
          end
        end
        S_RD_BYTE: begin
          if (scl_fall) begin
            if (cnt == 3'd7) begin
              oe_n    = 1'b0;
              ptr_n   = ptr + 2'd1;
              cnt_n   = 3'd0;
              state_n = S_RD_ACK;
            end else begin
              shift_n = {shift[6:0], 1'b0};
              oe_n    = ~shift[6];
              cnt_n   = cnt + 3'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s2) state_n = S_WAIT;
            else        pend_n  = 1'b1;
          end else if (scl_fall && pend) begin
            pend_n  = 1'b0;
            cnt_n   = 3'd0;
            shift_n = regs[ptr];
            oe_n    = ~regs[ptr][7];
            state_n = S_RD_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  // I2C write is applied last so it wins both the data and the dirty-bit collision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      dirty    <= 4'h0;
      readdata <= 32'h0;
    end else begin
      readdata <= {23'b0, dirty[address], regs[address]};
      if (av_wr) regs[address] <= writedata[7:0];
      if (av_rd) dirty[address] <= 1'b0;
      if (i2c_wr) begin
        regs[ptr]  <= shift;
        dirty[ptr] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_de2_115_sopc_i2c_target.sv
// tb/tb_de2_115_sopc_i2c_target.sv - scoreboard bench for the I2C target with Avalon CSR side
`timescale 1ns/1ps
module tb_de2_115_sopc_i2c_target;
  localparam int P = 12;
  localparam int Q = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        scl = 1'b1;
  logic        sda_low = 1'b0;
  wire         sda;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #10 clk = ~clk;

  de2_115_sopc_i2c_target #(.I2C_ADDR(7'h42)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .scl(scl), .sda(sda)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } item_t;

  item_t exp_q[$];
  item_t obs_q[$];
  item_t mon_o, mon_e;
  int    checks = 0;
  int    errors = 0;
  logic  rd_valid = 1'b0;

  always @(posedge clk) rd_valid <= chipselect && write_n;

  // Monitor: readdata is an output one clk after a read; I2C slots arrive via obs_q
  always @(negedge clk) begin
    if (rd_valid) obs_q.push_back('{"rd", readdata});
    while (obs_q.size() > 0) begin
      mon_o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual %0h required none", mon_o.val);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_o.val !== mon_e.val) begin
          errors++;
          $display("FAIL %s actual %0h required %0h", mon_e.name, mon_o.val, mon_e.val);
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_val(input string name, input logic [31:0] v);
    exp_q.push_back('{name, v});
  endtask

  task automatic observe(input logic [31:0] v);
    obs_q.push_back('{"obs", v});
  endtask

  task automatic av_write(input logic [1:0] a, input logic [7:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = {24'h0, d};
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic av_read(input logic [1:0] a, input logic [31:0] e, input string name);
    expect_val(name, e);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0;
    wait_clks(1);
  endtask

  task automatic send_bit(input logic b);
    sda_low = ~b;
    wait_clks(P); scl = 1'b1;
    wait_clks(P); scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_low = 1'b0;
    wait_clks(P); scl = 1'b1;
    wait_clks(P / 2); b = sda;
    wait_clks(P / 2); scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_start();
    sda_low = 1'b0;
    wait_clks(P); scl = 1'b1;
    wait_clks(P); sda_low = 1'b1;
    wait_clks(P); scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1;
    wait_clks(P); scl = 1'b1;
    wait_clks(P); sda_low = 1'b0;
    wait_clks(P);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic ack, input string name);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    expect_val(name, {31'b0, ack});
    read_bit(b);
    observe({31'b0, b});
  endtask

  task automatic read_byte(input logic [7:0] e, input logic nack, input string name);
    logic       b;
    logic [7:0] r;
    expect_val(name, {24'h0, e});
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      r[i] = b;
    end
    observe({24'h0, r});
    send_bit(nack);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       b;
    wait_clks(5);
    reset_n = 1'b1;
    wait_clks(5);

    // Reset asserted while the target holds the address ACK low
    av_write(0, 8'h11); av_write(1, 8'h22); av_write(2, 8'h33); av_write(3, 8'h44);
    av_read(2, 32'h033, "pre_reset_reg2");
    i2c_start();
    d = 8'h84;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    sda_low = 1'b0;
    wait_clks(1);
    expect_val("ack_before_reset", 32'h0);
    observe({31'b0, sda});
    reset_n = 1'b0;
    #1;
    expect_val("sda_released_in_reset", 32'h1);
    observe({31'b0, sda});
    wait_clks(3);
    scl = 1'b1;
    reset_n = 1'b1;
    wait_clks(P);
    for (int a = 0; a < 4; a++) av_read(a[1:0], 32'h0, "reset_readdata");

    // Write pointer 1 then two data bytes
    i2c_start();
    write_byte(8'h84, 1'b0, "wr_addr_ack");
    write_byte(8'h01, 1'b0, "wr_ptr_ack");
    write_byte(8'hAA, 1'b0, "wr_aa_ack");
    write_byte(8'hBB, 1'b0, "wr_bb_ack");
    i2c_stop();
    av_read(1, 32'h1AA, "reg1_dirty");
    av_read(1, 32'h0AA, "reg1_clean");
    av_read(2, 32'h1BB, "reg2_dirty");
    av_read(2, 32'h0BB, "reg2_clean");

    // Pointer left at 3 persists into the next transaction
    av_write(3, 8'h5A);
    i2c_start();
    write_byte(8'h85, 1'b0, "ptr_persist_addr_ack");
    read_byte(8'h5A, 1'b1, "ptr_persist_data");
    i2c_stop();

    // Address mismatch: every ACK slot stays released
    i2c_start();
    write_byte(8'h86, 1'b1, "mismatch_addr_nack");
    write_byte(8'h00, 1'b1, "mismatch_d0_nack");
    write_byte(8'h55, 1'b1, "mismatch_d1_nack");
    i2c_stop();
    av_read(0, 32'h000, "mismatch_reg0");
    av_read(1, 32'h0AA, "mismatch_reg1");
    av_read(2, 32'h0BB, "mismatch_reg2");
    av_read(3, 32'h05A, "mismatch_reg3");

    // Pointer 3, repeated START, read with wrap
    av_write(0, 8'h10); av_write(1, 8'h20); av_write(2, 8'h30); av_write(3, 8'h40);
    i2c_start();
    write_byte(8'h84, 1'b0, "rd_waddr_ack");
    write_byte(8'h03, 1'b0, "rd_ptr_ack");
    i2c_start();
    write_byte(8'h85, 1'b0, "rd_raddr_ack");
    read_byte(8'h40, 1'b0, "rd_byte0");
    read_byte(8'h10, 1'b0, "rd_byte1");
    read_byte(8'h20, 1'b1, "rd_byte2");
    expect_val("sda_after_nack", 32'h1);
    observe({31'b0, sda});
    i2c_stop();
    for (int a = 0; a < 4; a++) av_read(a[1:0], {24'h0, 4'(a + 1), 4'h0}, "rd_no_dirty");

    // STOP after four data bits abandons the byte
    i2c_start();
    write_byte(8'h84, 1'b0, "abort_addr_ack");
    write_byte(8'h00, 1'b0, "abort_ptr_ack");
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    i2c_stop();
    av_read(0, 32'h010, "abort_reg0");
    i2c_start();
    write_byte(8'h84, 1'b0, "post_abort_addr_ack");
    write_byte(8'h00, 1'b0, "post_abort_ptr_ack");
    write_byte(8'h5C, 1'b0, "post_abort_data_ack");
    i2c_stop();
    av_read(0, 32'h15C, "post_abort_reg0");

    // Avalon write lands on the same clk the I2C byte commits (3 clk after the 8th SCL fall)
    i2c_start();
    write_byte(8'h84, 1'b0, "col_addr_ack");
    write_byte(8'h02, 1'b0, "col_ptr_ack");
    d = 8'h99;
    for (int i = 7; i >= 1; i--) send_bit(d[i]);
    sda_low = ~d[0];
    wait_clks(P); scl = 1'b1;
    wait_clks(P); scl = 1'b0;
    wait_clks(2);
    chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h77;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    expect_val("col_data_ack", 32'h0);
    read_bit(b);
    observe({31'b0, b});
    i2c_stop();
    av_read(2, 32'h199, "col_reg2_dirty");
    av_read(2, 32'h099, "col_reg2_clean");

    wait_clks(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected actual %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
